// File: rtl/sram_req_ctrl_pkg.sv
// Shared constants and helpers for the SRAM request front-end.
package sram_req_ctrl_pkg;

  // Response buffer depth; also the number of reads allowed in flight.
  localparam int RSP_DEPTH = 2;

  // Advance a 1-bit ring pointer over the two buffer slots.
  function automatic logic ptr_inc(input logic p);
    return ~p;
  endfunction

  // A new read may be issued only if every outstanding read is
  // guaranteed a slot: buffered words plus the one arriving this cycle.
  function automatic logic credit_ok(input logic [1:0] occ, input logic pend);
    return (3'(occ) + 3'(pend)) < 3'(RSP_DEPTH);
  endfunction

endpackage

// File: rtl/sram_req_ctrl_rsp_skid_buf.sv
// Two-entry response FIFO; the parent handles the bypass path and
// only pushes words that could not be handed over directly.
module rsp_skid_buf
  import sram_req_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_head,
  output logic [1:0]            o_occ
);

  logic [RSP_DEPTH-1:0][DATA_WIDTH-1:0] w_entry;
  logic                                 r_wr_ptr;
  logic                                 r_rd_ptr;
  logic [1:0]                           r_occ;

  genvar gi;
  generate
    for (gi = 0; gi < RSP_DEPTH; gi++) begin : g_slot
      logic [DATA_WIDTH-1:0] r_entry;
      // Capture the pushed word into the slot the write pointer selects.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_entry <= '0;
        end else if (i_push && (r_wr_ptr == 1'(gi))) begin
          r_entry <= i_push_data;
        end
      end
      assign w_entry[gi] = r_entry;
    end
  endgenerate

  // Pointer and occupancy bookkeeping; push+pop together leaves occupancy unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_head = w_entry[r_rd_ptr];
  assign o_occ  = r_occ;

endmodule

// File: rtl/sram_req_ctrl.sv
// Request front-end for the single-port sram: clears every entry after
// reset, then forwards valid/ready requests and buffers read responses.
module sram_req_ctrl
  import sram_req_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    N_ENTRIES  = 128,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int                   AW         = $clog2(N_ENTRIES)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [AW-1:0]         req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  init_done_o,
  output logic                  sram_en_o,
  output logic                  sram_we_o,
  output logic [AW-1:0]         sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_data_o,
  input  logic [DATA_WIDTH-1:0] sram_data_i
);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_e;

  state_e                r_state, w_state_next;
  logic [AW-1:0]         r_cnt, w_cnt_next;
  logic                  r_rd_pending, w_rd_pending_next;
  logic                  w_ready, w_fire;
  logic                  w_empty, w_push, w_pop;
  logic [1:0]            w_occ;
  logic [DATA_WIDTH-1:0] w_head;

  // State, init counter and the one-cycle "read data arrives now" flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_INIT;
      r_cnt        <= '0;
      r_rd_pending <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_rd_pending <= w_rd_pending_next;
    end
  end

  // Next-state and SRAM pin drive: clear sweep in INIT, request pass-through in RUN.
  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_rd_pending_next = 1'b0;
    w_ready           = 1'b0;
    w_fire            = 1'b0;
    sram_en_o         = 1'b0;
    sram_we_o         = 1'b0;
    sram_addr_o       = '0;
    sram_data_o       = '0;
    case (r_state)
      S_INIT: begin
        sram_en_o   = 1'b1;
        sram_we_o   = 1'b1;
        sram_addr_o = r_cnt;
        sram_data_o = INIT_VALUE;
        w_cnt_next  = r_cnt + 1'b1;
        if (r_cnt == AW'(N_ENTRIES - 1)) begin
          w_state_next = S_RUN;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_ready           = credit_ok(w_occ, r_rd_pending);
        w_fire            = req_valid_i & w_ready;
        sram_en_o         = w_fire;
        sram_we_o         = req_we_i;
        sram_addr_o       = req_addr_i;
        sram_data_o       = req_data_i;
        w_rd_pending_next = w_fire & ~req_we_i;
      end
    endcase
  end

  assign req_ready_o = w_ready;
  assign init_done_o = (r_state == S_RUN);

  // Response path: head of buffer if non-empty, else the word straight from sram.
  assign w_empty     = (w_occ == 2'd0);
  assign rsp_valid_o = ~w_empty | r_rd_pending;
  assign rsp_data_o  = !w_empty ? w_head : (r_rd_pending ? sram_data_i : '0);
  assign w_pop       = ~w_empty & rsp_ready_i;
  assign w_push      = r_rd_pending & ~(w_empty & rsp_ready_i);

  rsp_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rsp_buf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_push      (w_push),
    .i_push_data (sram_data_i),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_occ       (w_occ)
  );

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl with a write-first sram model attached.
module tb_sram_req_ctrl;

  localparam int DW = 64;
  localparam int N  = 128;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          init_done;
  logic          sram_en, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;

  logic [DW-1:0] mem [N];

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [DW-1:0] DEAD = 64'hDEAD_BEEF_0000_0001;

  always #5 clk = ~clk;

  sram_req_ctrl #(.DATA_WIDTH(DW), .N_ENTRIES(N), .INIT_VALUE('0)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .init_done_o (init_done),
    .sram_en_o   (sram_en),
    .sram_we_o   (sram_we),
    .sram_addr_o (sram_addr),
    .sram_data_o (sram_wdata),
    .sram_data_i (sram_rdata)
  );

  // Write-first single-port sram with registered read data.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) begin
        mem[sram_addr] <= sram_wdata;
        sram_rdata     <= sram_wdata;
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  function automatic logic [DW-1:0] val(input int k);
    return 64'hC0DE_0000_0000_0000 | (64'(k) * 64'h0101);
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check outputs mid-cycle, advance past the edge.
  task automatic vec(input logic v, input logic we, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic rr,
                     input logic e_rdy, input logic e_rv, input logic [DW-1:0] e_d,
                     input string tag);
    req_valid = v; req_we = we; req_addr = a; req_data = d; rsp_ready = rr;
    #2;
    check({tag, "_ready"}, 64'(req_ready), 64'(e_rdy));
    check({tag, "_en"}, 64'(sram_en), 64'(v & e_rdy));
    check({tag, "_rvalid"}, 64'(rsp_valid), 64'(e_rv));
    if (e_rv) check({tag, "_rdata"}, rsp_data, e_d);
    $display("vec %s v=%0b we=%0b a=%0d rr=%0b ready=%0b rsp_valid=%0b rsp_data=%h",
             tag, v, we, a, rr, req_ready, rsp_valid, rsp_data);
    @(posedge clk); #1;
  endtask

  // Release reset and follow the clear sweep; called at posedge+1.
  task automatic init_seq(input string tag);
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) begin
      #2;
      check({tag, "_addr"}, 64'(sram_addr), 64'(k));
      check({tag, "_en"}, 64'(sram_en), 64'd1);
      check({tag, "_we"}, 64'(sram_we), 64'd1);
      check({tag, "_wdata"}, sram_wdata, 64'd0);
      check({tag, "_ready"}, 64'(req_ready), 64'd0);
      check({tag, "_done"}, 64'(init_done), 64'd0);
      @(posedge clk); #1;
    end
    #2;
    check({tag, "_done_hi"}, 64'(init_done), 64'd1);
    $display("init %s complete done=%0b", tag, init_done);
  endtask

  logic [AW-1:0] bp_addr [9]  = '{1, 2, 3, 3, 3, 3, 4, 0, 0};
  logic          bp_v    [9]  = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
  logic          bp_rr   [9]  = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
  logic          bp_rdy  [9]  = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
  logic          bp_rv   [9]  = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
  int            bp_didx [9]  = '{0, 1, 1, 1, 1, 2, 3, 4, 0};

  initial begin
    rst_n = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 7'd77; req_data = '0; rsp_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_rvalid", 64'(rsp_valid), 64'd0);
    check("rst_rdata", rsp_data, 64'd0);
    check("rst_done", 64'(init_done), 64'd0);
    check("rst_en", 64'(sram_en), 64'd1);
    check("rst_we", 64'(sram_we), 64'd1);
    check("rst_addr", 64'(sram_addr), 64'd0);
    check("rst_wdata", sram_wdata, 64'd0);
    @(posedge clk); #1;

    // Request held from reset: first acceptance on first RUN cycle.
    init_seq("init1");
    vec(1, 0, 77, 0, 1, 1, 0, 0, "rd77_acc");
    vec(0, 0, 0, 0, 1, 1, 1, 0, "rd77_rsp");
    vec(0, 0, 0, 0, 1, 1, 0, 0, "idle");

    // Write then read same address.
    vec(1, 1, 5, DEAD, 1, 1, 0, 0, "wr5");
    vec(1, 0, 5, 0, 1, 1, 0, 0, "rd5");
    vec(0, 0, 0, 0, 1, 1, 1, DEAD, "rsp5");
    vec(0, 0, 0, 0, 1, 1, 0, 0, "rsp5_end");

    // Back-to-back reads.
    for (int k = 1; k <= 4; k++) vec(1, 1, AW'(k), val(k), 1, 1, 0, 0, "wr_b2b");
    for (int i = 0; i <= 4; i++)
      vec(i < 4, 0, AW'(i + 1), 0, 1, 1, i > 0, (i > 0) ? val(i) : 64'd0, "b2b");
    vec(0, 0, 0, 0, 1, 1, 0, 0, "b2b_end");

    // Backpressure: two accepted, stall, then drain in order.
    for (int c = 0; c < 9; c++)
      vec(bp_v[c], 0, bp_addr[c], 0, bp_rr[c], bp_rdy[c], bp_rv[c],
          (bp_didx[c] > 0) ? val(bp_didx[c]) : 64'd0, "bp");

    // Two responses buffered, then async reset.
    vec(1, 0, 5, 0, 0, 1, 0, 0, "pre_rst_a");
    vec(1, 0, 1, 0, 0, 1, 1, DEAD, "pre_rst_b");
    vec(0, 0, 0, 0, 0, 0, 1, DEAD, "pre_rst_c");
    #2;
    check("buf_full_rvalid", 64'(rsp_valid), 64'd1);
    check("buf_full_ready", 64'(req_ready), 64'd0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", 64'(rsp_valid), 64'd0);
    check("mid_rst_rdata", rsp_data, 64'd0);
    check("mid_rst_done", 64'(init_done), 64'd0);
    check("mid_rst_addr", 64'(sram_addr), 64'd0);
    @(posedge clk); #1;
    init_seq("init2");

    // Every entry reads back as cleared, one read per cycle.
    for (int i = 0; i <= N; i++)
      vec(i < N, 0, AW'(i), 0, 1, 1, i > 0, 64'd0, "clr_rd");
    vec(0, 0, 0, 0, 1, 1, 0, 0, "clr_end");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
